mvau_act_replay_buf: RTL and testbench
======================================

// Module: mvau_act_replay_buf
// PURPOSE
// - Input-activation buffer directly upstream of mvau_stream.
// - Accepts one input vector (MatrixW elements) as SF=MatrixW/SIMD SIMD-wide words.
// - Streams the vector out NF=MatrixH/PE times, once per PE fold, so the MVAU never re-requests
//   activations; supplies matching weight-memory address and fold-boundary flags alongside each word.
// PARAMETERS
// - SIMD    2  activation elements per word (matches mvau_stream)
// - TSrcI   4  bits per activation element
// - MatrixW 8  input vector length (=KDim*KDim*IFMCh); must be a multiple of SIMD
// - MatrixH 4  output channels; must be a multiple of PE
// - PE      2  processing elements in mvau_stream
// PORTS
// - clk          in   1                   clock, all logic on rising edge
// - rst          in   1                   asynchronous, active-high reset
// - in_v         in   1                   upstream word valid
// - in_rdy       out  1                   buffer can accept word
// - in_act       in   SIMD*TSrcI          activation word, element k at bits [k*TSrcI +: TSrcI]
// - out_v        out  1                   output word valid
// - out_rdy      in   1                   mvau_stream accepts word
// - out_act      out  SIMD*TSrcI          activation word to mvau_stream
// - out_wgt_addr out  $clog2(SF*NF) (min 1) weight word index = nf*SF+sf
// - out_sf_last  out  1                   word is last of a vector pass (sf==SF-1)
// - out_nf_last  out  1                   word is last of the last pass (sf==SF-1 && nf==NF-1)
// BEHAVIOUR
// - Reset (async assert, sync release): state=FILL, sf=0, nf=0, out_v=0, out_act=0, out_wgt_addr=0,
//   flags=0, in_rdy=0 during rst. Buffer contents are not reset. Mid-operation reset drops the
//   partial vector; the next accepted word is sf=0 of a new vector.
// - Handshakes: valid/ready, transfer when v&&rdy on a clock edge. out_v/out_act/addr/flags are
//   registers, held stable while out_v&&!out_rdy. Output register loads when !out_v || out_rdy.
// - FILL (nf=0): in_rdy = !out_v || out_rdy. On input transfer: buf[sf]<=in_act, out_act<=in_act,
//   out_v<=1, addr=sf, flags from sf/nf. Latency input->output: 1 cycle. Full throughput, 1 word/clk.
// - In FILL at sf==SF-1 transfer: sf<=0; if NF==1 stay FILL (nf_last=1), else nf<=1 and go REPLAY.
// - REPLAY (nf>=1): in_rdy=0. Each cycle the output register may load: out_act<=buf[sf], addr=nf*SF+sf.
//   sf wraps at SF-1 with nf++. At sf==SF-1 && nf==NF-1: sf<=0, nf<=0, go FILL. FILL accepts the next
//   vector in that same loading cycle's successor; no bubble beyond the 1-cycle register.
// - Buffer: SF-entry x SIMD*TSrcI register array, combinational read, one write port. FILL writes
//   and REPLAY reads never collide (mutually exclusive states).
// - SF==1 and NF==1 are legal: counters stay 0; sf_last is constantly 1 on valid words.
// - Backpressure: out_rdy low freezes sf, nf, state and output registers; no word is skipped or
//   duplicated. in_v low in FILL leaves out_v to drop after the current word is taken.
// - Elaboration: $fatal if MatrixW%SIMD!=0 or MatrixH%PE!=0.
// STRUCTURE
// - Shared package mvau_defn: SIMD, TSrcI, MatrixW, MatrixH, PE, derived SF, NF,
//   typedef act_word_t (logic [SIMD-1:0][TSrcI-1:0]), typedef enum {FILL, REPLAY} rbuf_state_t.
// - One sub-module: mvau_fold_ctr (sf/nf counters with wrap, last flags, addr=nf*SF+sf).
// - Buffer and FSM remain in this top.
// TESTING
// - Defaults SF=4, NF=2; words A0..A3, out_rdy=1 ->
//   out_act A0,A1,A2,A3,A0,A1,A2,A3; addr 0..7; sf_last on addr 3,7; nf_last on addr 7 only.
// - Two back-to-back vectors A,B with in_v=1 ->
//   in_rdy low for exactly 4 cycles during replay; B0 appears immediately after the second A3.
// - out_rdy toggling 1,0,0,1 pseudo-random ->
//   out stream identical to the stalled-free sequence; out_act stable while stalled.
// - rst pulse asserted after A1 accepted, then vector C ->
//   out_v=0 immediately on rst; after release, first output is C0 with addr=0.
// - MatrixH=PE (NF=1), SIMD=MatrixW (SF=1) ->
//   pure 1-cycle pass-through, in_rdy never drops, sf_last=nf_last=1 every word.
// - Scoreboard vs golden replay model over 100 random vectors ->
//   zero mismatches; sink consumes exactly NF*SF words per vector.

Source files
------------

// File: rtl/mvau_act_replay_buf_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : mvau_defn (package)
//  Description : Shared MVAU activation-buffer parameters, derived fold
//                counts, activation word type and replay-buffer state type.
//  Revision    : 1.0 - initial release
// ============================================================================
package mvau_defn;

    localparam int SIMD    = 2;
    localparam int TSrcI   = 4;
    localparam int MatrixW = 8;
    localparam int MatrixH = 4;
    localparam int PE      = 2;
    localparam int SF      = MatrixW / SIMD;
    localparam int NF      = MatrixH / PE;

    typedef logic [SIMD-1:0][TSrcI-1:0] act_word_t;

    typedef enum logic [0:0] {
        FILL   = 1'b0,
        REPLAY = 1'b1
    } rbuf_state_t;

    // Index width that never collapses to zero bits for single-entry ranges
    function automatic int clog2_min1(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/mvau_act_replay_buf_fold_ctr.sv
`default_nettype none
// ============================================================================
//  Module      : mvau_fold_ctr
//  Description : SIMD-fold / PE-fold counters with wrap, fold-boundary flags
//                and weight word address nf*SF+sf.
//  Revision    : 1.0 - initial release
// ============================================================================
module mvau_fold_ctr
    import mvau_defn::*;
#(
    parameter int SF  = 4,
    parameter int NF  = 2,
    parameter int SFW = clog2_min1(SF),
    parameter int AW  = clog2_min1(SF * NF)
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           i_step,
    output logic [SFW-1:0] o_sf,
    output logic           o_sf_last,
    output logic           o_nf_last,
    output logic [AW-1:0]  o_addr
);

    localparam int NFW = clog2_min1(NF);

    logic [SFW-1:0] r_sf;
    logic [NFW-1:0] r_nf;
    logic           w_sf_last;
    logic           w_nf_last;

    assign w_sf_last = (r_sf == SFW'(SF - 1));
    assign w_nf_last = w_sf_last && (r_nf == NFW'(NF - 1));

    assign o_sf      = r_sf;
    assign o_sf_last = w_sf_last;
    assign o_nf_last = w_nf_last;
    assign o_addr    = AW'(int'(r_nf) * SF + int'(r_sf));

    // Advance sf each step; wrap sf into nf, and wrap both after the last pass
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_sf <= '0;
            r_nf <= '0;
        end else if (i_step) begin
            if (w_sf_last) begin
                r_sf <= '0;
                r_nf <= w_nf_last ? '0 : r_nf + 1'b1;
            end else begin
                r_sf <= r_sf + 1'b1;
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/mvau_act_replay_buf.sv
`default_nettype none
// ============================================================================
//  Module      : mvau_act_replay_buf
//  Description : Input-activation buffer for mvau_stream. Passes one vector
//                through while storing it, then replays it once per
//                remaining PE fold with matching weight address and flags.
//  Revision    : 1.0 - initial release
// ============================================================================
module mvau_act_replay_buf
    import mvau_defn::*;
#(
    parameter int SIMD    = mvau_defn::SIMD,
    parameter int TSrcI   = mvau_defn::TSrcI,
    parameter int MatrixW = mvau_defn::MatrixW,
    parameter int MatrixH = mvau_defn::MatrixH,
    parameter int PE      = mvau_defn::PE
) (
    input  logic                                                  clk,
    input  logic                                                  rst,
    input  logic                                                  in_v,
    output logic                                                  in_rdy,
    input  logic [SIMD*TSrcI-1:0]                                 in_act,
    output logic                                                  out_v,
    input  logic                                                  out_rdy,
    output logic [SIMD*TSrcI-1:0]                                 out_act,
    output logic [clog2_min1((MatrixW/SIMD)*(MatrixH/PE))-1:0]    out_wgt_addr,
    output logic                                                  out_sf_last,
    output logic                                                  out_nf_last
);

    localparam int C_SF  = MatrixW / SIMD;
    localparam int C_NF  = MatrixH / PE;
    localparam int C_W   = SIMD * TSrcI;
    localparam int C_SFW = clog2_min1(C_SF);
    localparam int C_AW  = clog2_min1(C_SF * C_NF);

    if (MatrixW % SIMD != 0) begin : g_bad_matrixw
        $fatal(1, "MatrixW must be a multiple of SIMD");
    end
    if (MatrixH % PE != 0) begin : g_bad_matrixh
        $fatal(1, "MatrixH must be a multiple of PE");
    end

    rbuf_state_t      r_state;
    logic [C_W-1:0]   r_buf [C_SF];

    logic             w_out_free;
    logic             w_in_xfer;
    logic             w_step;
    logic [C_SFW-1:0] w_sf;
    logic             w_sf_last;
    logic             w_nf_last;
    logic [C_AW-1:0]  w_addr;

    // Output register may load whenever it is empty or being drained
    assign w_out_free = !out_v || out_rdy;
    assign in_rdy     = !rst && (r_state == FILL) && w_out_free;
    assign w_in_xfer  = in_v && in_rdy;
    // One fold word is produced per step: an accepted input in FILL, a buffer read in REPLAY
    assign w_step     = (r_state == FILL) ? w_in_xfer : w_out_free;

    mvau_fold_ctr #(
        .SF  (C_SF),
        .NF  (C_NF),
        .SFW (C_SFW),
        .AW  (C_AW)
    ) u_fold_ctr (
        .clk       (clk),
        .rst       (rst),
        .i_step    (w_step),
        .o_sf      (w_sf),
        .o_sf_last (w_sf_last),
        .o_nf_last (w_nf_last),
        .o_addr    (w_addr)
    );

    // Capture each accepted word of the first pass for later replay (contents not reset)
    always_ff @(posedge clk) begin
        if (w_in_xfer) begin
            r_buf[w_sf] <= in_act;
        end
    end

    // FILL/REPLAY sequencing and the registered output word with its address and flags
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state      <= FILL;
            out_v        <= 1'b0;
            out_act      <= '0;
            out_wgt_addr <= '0;
            out_sf_last  <= 1'b0;
            out_nf_last  <= 1'b0;
        end else begin
            if (w_out_free) begin
                out_v <= w_step;
                if (w_step) begin
                    out_act      <= (r_state == FILL) ? in_act : r_buf[w_sf];
                    out_wgt_addr <= w_addr;
                    out_sf_last  <= w_sf_last;
                    out_nf_last  <= w_nf_last;
                end
            end
            case (r_state)
                FILL: begin
                    if (w_in_xfer && w_sf_last && (C_NF != 1)) begin
                        r_state <= REPLAY;
                    end
                end
                REPLAY: begin
                    if (w_step && w_nf_last) begin
                        r_state <= FILL;
                    end
                end
                default: r_state <= FILL;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_mvau_act_replay_buf.sv
`default_nettype none
// ============================================================================
//  Module      : tb_mvau_act_replay_buf
//  Description : Self-checking bench for mvau_act_replay_buf (default fold
//                configuration plus a single-fold pass-through instance).
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_mvau_act_replay_buf;

    localparam int SF = 4;
    localparam int NF = 2;

    logic       clk = 1'b0;
    logic       rst;
    logic       in_v;
    logic       in_rdy;
    logic [7:0] in_act;
    logic       out_v;
    logic       out_rdy;
    logic [7:0] out_act;
    logic [2:0] out_wgt_addr;
    logic       out_sf_last;
    logic       out_nf_last;

    logic        p_in_v;
    logic        p_in_rdy;
    logic [31:0] p_in_act;
    logic        p_out_v;
    logic        p_out_rdy;
    logic [31:0] p_out_act;
    logic [0:0]  p_out_wgt_addr;
    logic        p_out_sf_last;
    logic        p_out_nf_last;

    always #5 clk = ~clk;

    mvau_act_replay_buf u_dut (
        .clk          (clk),
        .rst          (rst),
        .in_v         (in_v),
        .in_rdy       (in_rdy),
        .in_act       (in_act),
        .out_v        (out_v),
        .out_rdy      (out_rdy),
        .out_act      (out_act),
        .out_wgt_addr (out_wgt_addr),
        .out_sf_last  (out_sf_last),
        .out_nf_last  (out_nf_last)
    );

    mvau_act_replay_buf #(
        .SIMD    (8),
        .TSrcI   (4),
        .MatrixW (8),
        .MatrixH (2),
        .PE      (2)
    ) u_dut_pass (
        .clk          (clk),
        .rst          (rst),
        .in_v         (p_in_v),
        .in_rdy       (p_in_rdy),
        .in_act       (p_in_act),
        .out_v        (p_out_v),
        .out_rdy      (p_out_rdy),
        .out_act      (p_out_act),
        .out_wgt_addr (p_out_wgt_addr),
        .out_sf_last  (p_out_sf_last),
        .out_nf_last  (p_out_nf_last)
    );

    // Reference model: every output word still owed to the sink, in order
    typedef struct {
        logic [7:0] act;
        int         addr;
        logic       sl;
        logic       nl;
    } exp_t;

    exp_t       q[$];
    logic [7:0] cur_vec [SF];
    int         vec_idx  = 0;
    int         n_vec    = 0;
    int         n_err    = 0;
    int         n_out    = 0;
    int         n_block  = 0;
    int         rdy_mode = 0;
    int         pat_i    = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Word k of a vector is seen once immediately, then once per extra PE fold
    task automatic model_accept(input logic [7:0] a);
        exp_t e;
        cur_vec[vec_idx] = a;
        e.act  = a;
        e.addr = vec_idx;
        e.sl   = (vec_idx == SF - 1);
        e.nl   = (NF == 1) && (vec_idx == SF - 1);
        q.push_back(e);
        if (vec_idx == SF - 1) begin
            for (int n = 1; n < NF; n++) begin
                for (int s = 0; s < SF; s++) begin
                    e.act  = cur_vec[s];
                    e.addr = n * SF + s;
                    e.sl   = (s == SF - 1);
                    e.nl   = (n == NF - 1) && (s == SF - 1);
                    q.push_back(e);
                end
            end
            vec_idx = 0;
        end else begin
            vec_idx++;
        end
    endtask

    function automatic logic next_rdy();
        logic [3:0] pat;
        logic       r;
        pat = 4'b1001;
        case (rdy_mode)
            0:       r = 1'b1;
            1:       begin r = pat[3 - (pat_i % 4)]; pat_i++; end
            default: r = 1'($urandom_range(0, 1));
        endcase
        return r;
    endfunction

    // One clock: drive at the falling edge, check 1 ns later, account for the rising-edge transfers
    task automatic step(input logic v, input logic [7:0] a, input logic ordy, output logic acc);
        int sz;
        in_v    = v;
        in_act  = a;
        out_rdy = ordy;
        #1;
        sz = q.size();
        chk("out_v", 64'(out_v), 64'(sz != 0));
        chk("in_rdy", 64'(in_rdy), 64'((sz == 0) || (sz == 1 && ordy)));
        if (out_v && sz != 0)
            chk("out_word", 64'({out_act, out_wgt_addr, out_sf_last, out_nf_last}),
                64'({q[0].act, 3'(q[0].addr), q[0].sl, q[0].nl}));
        acc = in_v && in_rdy;
        if (in_v && !in_rdy) n_block++;
        if (out_v && out_rdy) begin
            if (sz != 0) void'(q.pop_front());
            n_out++;
        end
        if (acc) model_accept(a);
        @(negedge clk);
    endtask

    task automatic send_word(input logic [7:0] a);
        logic acc;
        acc = 1'b0;
        for (int i = 0; i < 60 && !acc; i++) step(1'b1, a, next_rdy(), acc);
        if (!acc) chk("accept_timeout", 64'(0), 64'(1));
    endtask

    task automatic drain();
        logic acc;
        for (int i = 0; i < 200 && q.size() != 0; i++) step(1'b0, 8'($urandom), next_rdy(), acc);
        chk("drain_left", 64'(q.size()), 64'(0));
        step(1'b0, 8'h00, 1'b1, acc);
    endtask

    task automatic do_reset();
        rst  = 1'b1;
        in_v = 1'b0;
        #1;
        chk("rst_out_v", 64'(out_v), 64'(0));
        chk("rst_in_rdy", 64'(in_rdy), 64'(0));
        chk("rst_regs", 64'({out_act, out_wgt_addr, out_sf_last, out_nf_last}), 64'(0));
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        q.delete();
        vec_idx = 0;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic       acc;
        logic       prev_x;
        logic [31:0] prev_a;
        int         out0;

        rst = 1'b1; in_v = 1'b0; in_act = '0; out_rdy = 1'b0;
        p_in_v = 1'b0; p_in_act = '0; p_out_rdy = 1'b1;
        @(negedge clk);
        do_reset();

        // Single vector, free-running sink
        rdy_mode = 0;
        for (int s = 0; s < SF; s++) send_word(8'hA0 + 8'(s));
        drain();

        // Two back-to-back vectors: input must be blocked for exactly one replay pass
        n_block = 0;
        for (int s = 0; s < SF; s++) send_word(8'hA0 + 8'(s));
        for (int s = 0; s < SF; s++) send_word(8'hB0 + 8'(s));
        drain();
        chk("b2b_block_cycles", 64'(n_block), 64'(SF * (NF - 1)));

        // Patterned backpressure
        rdy_mode = 1;
        for (int v = 0; v < 3; v++)
            for (int s = 0; s < SF; s++) send_word(8'(v * 16 + s + 8'h30));
        drain();

        // Reset after two words of a vector, then a fresh vector
        rdy_mode = 0;
        send_word(8'hA0);
        send_word(8'hA1);
        do_reset();
        for (int s = 0; s < SF; s++) send_word(8'hC0 + 8'(s));
        drain();

        // Randomised traffic with random gaps and random backpressure
        rdy_mode = 2;
        out0 = n_out;
        for (int v = 0; v < 100; v++) begin
            for (int s = 0; s < SF; s++) begin
                if ($urandom_range(0, 3) == 0) step(1'b0, 8'($urandom), next_rdy(), acc);
                send_word(8'($urandom));
            end
        end
        drain();
        chk("sink_word_count", 64'(n_out - out0), 64'(100 * SF * NF));

        // Single-fold instance: pure one-cycle pass-through
        prev_x = 1'b0;
        prev_a = '0;
        for (int i = 0; i < 40; i++) begin
            p_in_v    = 1'($urandom_range(0, 1));
            p_in_act  = $urandom;
            p_out_rdy = 1'b1;
            #1;
            chk("pass_in_rdy", 64'(p_in_rdy), 64'(1));
            chk("pass_out_v", 64'(p_out_v), 64'(prev_x));
            if (prev_x)
                chk("pass_word", 64'({p_out_act, p_out_wgt_addr, p_out_sf_last, p_out_nf_last}),
                    64'({prev_a, 1'b0, 1'b1, 1'b1}));
            prev_x = p_in_v && p_in_rdy;
            prev_a = p_in_act;
            @(negedge clk);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
